call_ret_stack: RTL and testbench
=================================

Name: call_ret_stack

Overview:
- Hardware return-address stack for the behavioural task/function call sequencer.
- Sits directly downstream of the call decode stage: a call pushes a return address, a return pops one.
- Flags misuse as sticky faults: a return with no frame open (underflow) and nesting deeper than capacity (overflow).
- While faulted, the stack freezes until software clears the fault.

Parameters:
- AW, 8, return-address width in bits.
- DEPTH, 8, number of frames; power of two, 2..64.
- CW, $clog2(DEPTH+1), width of the depth counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- call_i  input  1  push request, one frame per cycle when high.
- call_addr_i  input  AW  return address to push.
- ret_i  input  1  pop request, one frame per cycle when high.
- ret_valid_o  output  1  one-cycle pulse: ret_addr_o is valid.
- ret_addr_o  output  AW  popped return address (registered).
- depth_o  output  CW  frames currently held, 0..DEPTH.
- empty_o  output  1  depth_o == 0.
- full_o  output  1  depth_o == DEPTH.
- fault_o  output  1  high while in state FAULT.
- fault_code_o  output  2  00 none, 01 underflow, 10 overflow; held while in FAULT.
- fault_clr_i  input  1  leave FAULT and empty the stack.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low.
- Reset values: all outputs 0 except empty_o = 1. Internal state: RUN, depth = 0. Frame storage is not reset.
- Reset mid-operation: any in-flight pop pulse is dropped. No ret_valid_o after deassertion until a new ret_i.
- States: RUN and FAULT.
- RUN, call_i only:
  - If not full: write call_addr_i at index depth; depth += 1.
  - If full: overflow. Go to FAULT, code 10, depth unchanged, storage unchanged.
- RUN, ret_i only:
  - If not empty: next cycle ret_addr_o = frame[depth-1] and ret_valid_o = 1 (1-cycle latency); depth -= 1.
  - If empty: underflow. Go to FAULT, code 01, no ret_valid_o pulse.
- RUN, call_i and ret_i together (tail call):
  - If not empty: ret_addr_o = old top, ret_valid_o = 1 next cycle; top frame overwritten with call_addr_i; depth unchanged; never overflow, even when full.
  - If empty: pass-through. ret_addr_o = call_addr_i, ret_valid_o = 1 next cycle, depth stays 0, no fault.
- FAULT:
  - call_i and ret_i are ignored. depth_o, storage and fault_code_o hold. ret_valid_o = 0.
  - fault_clr_i = 1: next cycle state RUN, depth = 0, fault_code_o = 00, fault_o = 0.
  - A call_i or ret_i in the same cycle as fault_clr_i is ignored.
- fault_clr_i in RUN: no effect.
- ret_addr_o holds its last popped value between pulses.
- Arithmetic: depth is unsigned CW-bit; it can never wrap because the fault rules block it. The frame index uses the low $clog2(DEPTH) bits.
- Flags: empty_o, full_o and depth_o are registered and consistent in the same cycle.

Test Plan:
- Three pops in order: AW=8, DEPTH=8; call 0x11, 0x22, 0x33 on consecutive cycles, then ret three cycles -> ret_addr_o 0x33, 0x22, 0x11, each one cycle after its ret_i; depth_o 3→0; empty_o = 1 at end.
- Overflow: 8 calls, then a 9th call 0xAA -> full_o = 1 after the 8th; 9th gives fault_o = 1, fault_code_o = 10, depth_o = 8. Then ret_i is ignored (no pulse). Then fault_clr_i -> depth_o = 0, fault_o = 0.
- Underflow: ret_i out of reset -> fault_code_o = 01 next cycle, ret_valid_o never pulses. A call 0x05 while faulted leaves depth_o = 0.
- Tail call: at depth 2, top 0x40, drive call 0x77 with ret -> ret_addr_o = 0x40 pulse, depth_o = 2; next ret returns 0x77. Repeat at full -> no overflow. Empty call+ret with 0x09 -> pulse 0x09, depth_o = 0.
- Async reset mid-pop: at depth 3, assert ret_i and drop rst_n mid-cycle -> outputs clear immediately with empty_o = 1; no ret_valid_o after release.

Source files
------------

// File: rtl/call_ret_stack.sv
// call_ret_stack: hardware return-address stack for the call sequencer.
// A call pushes a return address, a return pops one with one cycle of
// latency. A simultaneous call and return is a tail call that replaces
// the top frame. Underflow and overflow are sticky faults that freeze the
// stack until fault_clr_i is asserted.
module call_ret_stack #(
  parameter int AW    = 8,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          call_i,
  input  logic [AW-1:0] call_addr_i,
  input  logic          ret_i,
  output logic          ret_valid_o,
  output logic [AW-1:0] ret_addr_o,
  output logic [CW-1:0] depth_o,
  output logic          empty_o,
  output logic          full_o,
  output logic          fault_o,
  output logic [1:0]    fault_code_o,
  input  logic          fault_clr_i
);

  localparam int IW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } state_t;

  state_t        state;
  logic [CW-1:0] depth;
  logic          empty_q;
  logic          full_q;
  logic          ret_valid_q;
  logic [AW-1:0] ret_addr_q;
  logic          fault_q;
  logic [1:0]    fault_code_q;

  logic [AW-1:0] frames [DEPTH];

  logic          in_run;
  logic          do_push;
  logic          do_pop;
  logic          do_tail;
  logic          do_pass;
  logic          do_ovf;
  logic          do_unf;
  logic          do_clr;
  logic [CW-1:0] depth_m1;
  logic [IW-1:0] top_idx;
  logic [IW-1:0] push_idx;
  logic [CW-1:0] depth_nxt;

  // Decode the requested operation and the resulting frame count.
  always_comb begin
    in_run    = (state == RUN);
    do_tail   = in_run && call_i && ret_i && !empty_q;
    do_pass   = in_run && call_i && ret_i && empty_q;
    do_push   = in_run && call_i && !ret_i && !full_q;
    do_ovf    = in_run && call_i && !ret_i && full_q;
    do_pop    = in_run && ret_i && !call_i && !empty_q;
    do_unf    = in_run && ret_i && !call_i && empty_q;
    do_clr    = (state == FAULT) && fault_clr_i;
    depth_m1  = depth - 1'b1;
    top_idx   = depth_m1[IW-1:0];
    push_idx  = depth[IW-1:0];
    depth_nxt = depth;
    if (do_push) begin
      depth_nxt = depth + 1'b1;
    end else if (do_pop) begin
      depth_nxt = depth_m1;
    end else if (do_clr) begin
      depth_nxt = '0;
    end
  end

  // Frame storage: push writes above the top, tail call rewrites the top.
  always_ff @(posedge clk) begin
    if (do_push) begin
      frames[push_idx] <= call_addr_i;
    end else if (do_tail) begin
      frames[top_idx] <= call_addr_i;
    end
  end

  // Control FSM with registered depth, flags, pop result and fault status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RUN;
      depth        <= '0;
      empty_q      <= 1'b1;
      full_q       <= 1'b0;
      ret_valid_q  <= 1'b0;
      ret_addr_q   <= '0;
      fault_q      <= 1'b0;
      fault_code_q <= 2'b00;
    end else begin
      depth       <= depth_nxt;
      empty_q     <= (depth_nxt == '0);
      full_q      <= (depth_nxt == DEPTH_C);
      ret_valid_q <= 1'b0;
      case (state)
        RUN: begin
          if (do_tail || do_pop) begin
            ret_addr_q  <= frames[top_idx];
            ret_valid_q <= 1'b1;
          end else if (do_pass) begin
            ret_addr_q  <= call_addr_i;
            ret_valid_q <= 1'b1;
          end else if (do_ovf) begin
            state        <= FAULT;
            fault_q      <= 1'b1;
            fault_code_q <= 2'b10;
          end else if (do_unf) begin
            state        <= FAULT;
            fault_q      <= 1'b1;
            fault_code_q <= 2'b01;
          end
        end
        FAULT: begin
          if (do_clr) begin
            state        <= RUN;
            fault_q      <= 1'b0;
            fault_code_q <= 2'b00;
          end
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

  assign ret_valid_o  = ret_valid_q;
  assign ret_addr_o   = ret_addr_q;
  assign depth_o      = depth;
  assign empty_o      = empty_q;
  assign full_o       = full_q;
  assign fault_o      = fault_q;
  assign fault_code_o = fault_code_q;

endmodule

// File: tb/tb_call_ret_stack.sv
// tb_call_ret_stack: directed vectors with hand-computed expectations for
// the return-address stack (AW=8, DEPTH=8).
module tb_call_ret_stack;

  localparam int AW    = 8;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk;
  logic          rst_n;
  logic          call_i;
  logic [AW-1:0] call_addr_i;
  logic          ret_i;
  logic          ret_valid_o;
  logic [AW-1:0] ret_addr_o;
  logic [CW-1:0] depth_o;
  logic          empty_o;
  logic          full_o;
  logic          fault_o;
  logic [1:0]    fault_code_o;
  logic          fault_clr_i;

  int vectors;
  int miscompares;

  call_ret_stack #(.AW(AW), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .call_i       (call_i),
    .call_addr_i  (call_addr_i),
    .ret_i        (ret_i),
    .ret_valid_o  (ret_valid_o),
    .ret_addr_o   (ret_addr_o),
    .depth_o      (depth_o),
    .empty_o      (empty_o),
    .full_o       (full_o),
    .fault_o      (fault_o),
    .fault_code_o (fault_code_o),
    .fault_clr_i  (fault_clr_i)
  );

  // 10 ns free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, then settle just after the rising edge.
  task automatic applyStimulus(input logic c, input logic [AW-1:0] a,
                               input logic r, input logic clr);
    @(negedge clk);
    call_i      = c;
    call_addr_i = a;
    ret_i       = r;
    fault_clr_i = clr;
    @(posedge clk);
    #1;
  endtask

  // Check the idle/reset output set.
  task automatic checkReset(input string tag);
    checkOutput({tag, ".valid"}, 32'(ret_valid_o), 32'h0);
    checkOutput({tag, ".addr"},  32'(ret_addr_o),  32'h0);
    checkOutput({tag, ".depth"}, 32'(depth_o),     32'h0);
    checkOutput({tag, ".empty"}, 32'(empty_o),     32'h1);
    checkOutput({tag, ".full"},  32'(full_o),      32'h0);
    checkOutput({tag, ".fault"}, 32'(fault_o),     32'h0);
    checkOutput({tag, ".code"},  32'(fault_code_o), 32'h0);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n       = 1'b0;
    call_i      = 1'b0;
    call_addr_i = '0;
    ret_i       = 1'b0;
    fault_clr_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    call_i      = 1'b0;
    call_addr_i = '0;
    ret_i       = 1'b0;
    fault_clr_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkReset("rst");
    doReset();

    // Three pushes then three pops in LIFO order.
    applyStimulus(1'b1, 8'h11, 1'b0, 1'b0);
    checkOutput("push1.depth", 32'(depth_o), 32'd1);
    checkOutput("push1.empty", 32'(empty_o), 32'd0);
    applyStimulus(1'b1, 8'h22, 1'b0, 1'b0);
    checkOutput("push2.depth", 32'(depth_o), 32'd2);
    applyStimulus(1'b1, 8'h33, 1'b0, 1'b0);
    checkOutput("push3.depth", 32'(depth_o), 32'd3);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("pop1.valid", 32'(ret_valid_o), 32'd1);
    checkOutput("pop1.addr",  32'(ret_addr_o),  32'h33);
    checkOutput("pop1.depth", 32'(depth_o),     32'd2);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("pop2.addr",  32'(ret_addr_o),  32'h22);
    checkOutput("pop2.depth", 32'(depth_o),     32'd1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("pop3.valid", 32'(ret_valid_o), 32'd1);
    checkOutput("pop3.addr",  32'(ret_addr_o),  32'h11);
    checkOutput("pop3.depth", 32'(depth_o),     32'd0);
    checkOutput("pop3.empty", 32'(empty_o),     32'd1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("idle.valid", 32'(ret_valid_o), 32'd0);
    checkOutput("idle.hold",  32'(ret_addr_o),  32'h11);

    // Overflow: fill, then one more call.
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
      checkOutput("fill.depth", 32'(depth_o), 32'(i + 1));
      checkOutput("fill.full",  32'(full_o),  32'((i == DEPTH - 1) ? 1 : 0));
    end
    applyStimulus(1'b1, 8'hAA, 1'b0, 1'b0);
    checkOutput("ovf.fault", 32'(fault_o),      32'd1);
    checkOutput("ovf.code",  32'(fault_code_o), 32'd2);
    checkOutput("ovf.depth", 32'(depth_o),      32'd8);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("ovfret.valid", 32'(ret_valid_o),  32'd0);
    checkOutput("ovfret.depth", 32'(depth_o),      32'd8);
    checkOutput("ovfret.code",  32'(fault_code_o), 32'd2);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("ovfclr.depth", 32'(depth_o),      32'd0);
    checkOutput("ovfclr.fault", 32'(fault_o),      32'd0);
    checkOutput("ovfclr.code",  32'(fault_code_o), 32'd0);
    checkOutput("ovfclr.empty", 32'(empty_o),      32'd1);
    checkOutput("ovfclr.full",  32'(full_o),       32'd0);

    // Underflow straight out of reset.
    doReset();
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("unf.valid", 32'(ret_valid_o),  32'd0);
    checkOutput("unf.fault", 32'(fault_o),      32'd1);
    checkOutput("unf.code",  32'(fault_code_o), 32'd1);
    applyStimulus(1'b1, 8'h05, 1'b0, 1'b0);
    checkOutput("unfcall.depth", 32'(depth_o),      32'd0);
    checkOutput("unfcall.code",  32'(fault_code_o), 32'd1);
    applyStimulus(1'b1, 8'h06, 1'b0, 1'b1);
    checkOutput("unfclr.depth", 32'(depth_o), 32'd0);
    checkOutput("unfclr.fault", 32'(fault_o), 32'd0);

    // Tail call at depth 2, then pop the replaced frame.
    applyStimulus(1'b1, 8'h30, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h40, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h77, 1'b1, 1'b0);
    checkOutput("tail.valid", 32'(ret_valid_o), 32'd1);
    checkOutput("tail.addr",  32'(ret_addr_o),  32'h40);
    checkOutput("tail.depth", 32'(depth_o),     32'd2);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("tailpop.addr",  32'(ret_addr_o), 32'h77);
    checkOutput("tailpop.depth", 32'(depth_o),    32'd1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("tailpop2.addr", 32'(ret_addr_o), 32'h30);

    // Tail call while full never overflows.
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
    end
    applyStimulus(1'b1, 8'hBB, 1'b1, 1'b0);
    checkOutput("tailfull.addr",  32'(ret_addr_o), 32'h57);
    checkOutput("tailfull.depth", 32'(depth_o),    32'd8);
    checkOutput("tailfull.fault", 32'(fault_o),    32'd0);
    checkOutput("tailfull.full",  32'(full_o),     32'd1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("tailfullpop.addr",  32'(ret_addr_o), 32'hBB);
    checkOutput("tailfullpop.depth", 32'(depth_o),    32'd7);
    for (int i = DEPTH - 2; i >= 0; i--) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("drain.addr", 32'(ret_addr_o), 32'(8'h50 + i));
    end
    checkOutput("drain.empty", 32'(empty_o), 32'd1);

    // Empty call+ret passes the address straight through.
    applyStimulus(1'b1, 8'h09, 1'b1, 1'b0);
    checkOutput("pass.valid", 32'(ret_valid_o), 32'd1);
    checkOutput("pass.addr",  32'(ret_addr_o),  32'h09);
    checkOutput("pass.depth", 32'(depth_o),     32'd0);
    checkOutput("pass.fault", 32'(fault_o),     32'd0);

    // fault_clr_i has no effect while running.
    applyStimulus(1'b1, 8'h12, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("runclr.depth", 32'(depth_o), 32'd1);

    // Asynchronous reset while a pop pulse is in flight.
    applyStimulus(1'b1, 8'h13, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h14, 1'b0, 1'b0);
    checkOutput("pre.depth", 32'(depth_o), 32'd3);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("inflight.valid", 32'(ret_valid_o), 32'd1);
    checkOutput("inflight.addr",  32'(ret_addr_o),  32'h14);
    #1;
    rst_n = 1'b0;
    #1;
    checkReset("arst");
    @(negedge clk);
    ret_i = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkOutput("postrst.valid", 32'(ret_valid_o), 32'd0);
      checkOutput("postrst.depth", 32'(depth_o),     32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
